// File: rtl/axi_uart_pkg.sv
// Shared types and constants for the AXI read-back to UART transmit path.
package axi_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_SEND,
        ST_NEXT,
        ST_FIN
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_AXI_DATA_WIDTH = 128;
    localparam int unsigned BYTES_PER_WORD     = DEF_AXI_DATA_WIDTH / DEF_DATA_WIDTH;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_rd_uart_tx_uart_tx.sv
// UART 8N1-style transmitter; a new frame may be loaded on the last cycle of
// the previous stop bit so consecutive characters have no idle gap.
module uart_tx
    import axi_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx
);

    localparam int unsigned FRAME_BITS = DATA_WIDTH + 2;
    localparam int unsigned BAUD_W = (clog2(CLKS_PER_BIT) > 0) ? clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = clog2(FRAME_BITS);

    logic [BAUD_W-1:0]   r_baud_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH:0] r_shift;
    logic                r_busy;
    logic                r_tx;

    logic w_bit_end;
    logic w_frame_end;
    logic w_load;

    assign w_bit_end   = r_busy && (r_baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_frame_end = w_bit_end && (r_bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign w_load      = tx_start && (!r_busy || w_frame_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '1;
            r_busy     <= 1'b0;
            r_tx       <= 1'b1;
        end else if (w_load) begin
            // start bit goes out now; r_shift holds data then stop bit
            r_shift    <= {1'b1, tx_data};
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_frame_end) begin
            r_busy     <= 1'b0;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            r_tx       <= r_shift[0];
            r_shift    <= {1'b1, r_shift[DATA_WIDTH:1]};
        end else if (r_busy) begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    assign tx_busy = r_busy;
    assign tx_done = w_frame_end;
    assign tx      = r_tx;

endmodule

// File: rtl/axi_rd_uart_tx.sv
// Reads consecutive AXI words one beat at a time and streams each word out
// over UART, least-significant character first.
module axi_rd_uart_tx
    import axi_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned BAUD_RATE      = 115200,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 128,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] start_addr,
    input  logic [CNT_WIDTH-1:0]      num_words,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic                      tx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned WORD_BYTES   = AXI_DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB     = clog2(WORD_BYTES);
    localparam int unsigned CHARS        = AXI_DATA_WIDTH / DATA_WIDTH;
    localparam int unsigned CHAR_W       = clog2(CHARS + 1);

    state_t                    r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]      r_count;
    logic [AXI_DATA_WIDTH-1:0] r_buf;
    logic [CHAR_W-1:0]         r_chars_left;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;
    logic                      r_arvalid;
    logic                      r_rready;

    logic w_tx_start;
    logic w_tx_busy;
    logic w_tx_done;
    logic w_accept;
    logic w_unused_rlast;

    assign w_unused_rlast = m_axi_rlast;

    // tx_start is held as a request; the transmitter takes it when idle or at a frame end
    assign w_tx_start = (r_state == ST_SEND) && (r_chars_left != '0);
    assign w_accept   = w_tx_start && (!w_tx_busy || w_tx_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_count      <= '0;
            r_buf        <= '0;
            r_chars_left <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            r_addr    <= start_addr & ~AXI_ADDR_WIDTH'(WORD_BYTES - 1);
                            r_count   <= num_words;
                            r_err     <= 1'b0;
                            r_busy    <= 1'b1;
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end
                    end
                end
                ST_AR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_axi_rvalid) begin
                        r_rready <= 1'b0;
                        if (m_axi_rresp != AXI_RESP_OKAY) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_buf        <= m_axi_rdata;
                            r_chars_left <= CHAR_W'(CHARS);
                            r_state      <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        r_buf        <= r_buf >> DATA_WIDTH;
                        r_chars_left <= r_chars_left - 1'b1;
                    end
                    if ((r_chars_left == '0) && w_tx_done) r_state <= ST_NEXT;
                end
                ST_NEXT: begin
                    r_count <= r_count - 1'b1;
                    r_addr  <= r_addr + AXI_ADDR_WIDTH'(WORD_BYTES);
                    if (r_count != CNT_WIDTH'(1)) begin
                        r_arvalid <= 1'b1;
                        r_state   <= ST_AR;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    uart_tx #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_start(w_tx_start),
        .tx_data (r_buf[DATA_WIDTH-1:0]),
        .tx_busy (w_tx_busy),
        .tx_done (w_tx_done),
        .tx      (tx)
    );

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'(ADDR_LSB);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: doc/axi_rd_uart_tx.md
Name: axi_rd_uart_tx

Overview:
Read-back path for the UART-to-DDR datapath. On command, it issues single-beat AXI4 read transactions for consecutive 128-bit memory words. Each returned word is serialised LSB-byte-first onto a UART 8N1 transmitter. It mirrors the write-side packing, where the first received UART byte lands in rdata[7:0].

Parameters:
DATA_WIDTH, 8, UART character width in bits.
CLK_FREQ, 100_000_000, clk frequency in Hz.
BAUD_RATE, 115200, UART bit rate.
AXI_ADDR_WIDTH, 32, AXI address width.
AXI_DATA_WIDTH, 128, AXI read data width; must be a multiple of DATA_WIDTH.
CNT_WIDTH, 16, width of the word-count input.

Ports:
clk  in  1  system clock; all logic is single-clock.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; sampled only in IDLE.
start_addr  in  AXI_ADDR_WIDTH  byte address of the first word; low 4 bits ignored (forced to 0).
num_words  in  CNT_WIDTH  number of 128-bit words to send.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse at the end of a job.
err  out  1  sticky SLVERR/DECERR flag; cleared by the next accepted start or by rst.
m_axi_araddr  out  AXI_ADDR_WIDTH  read address.
m_axi_arlen  out  8  constant 0 (single beat).
m_axi_arsize  out  3  constant log2(AXI_DATA_WIDTH/8).
m_axi_arburst  out  2  constant 2'b01 (INCR).
m_axi_arvalid  out  1  address valid.
m_axi_arready  in  1  address ready.
m_axi_rdata  in  AXI_DATA_WIDTH  read data.
m_axi_rresp  in  2  read response.
m_axi_rlast  in  1  ignored (single beat).
m_axi_rvalid  in  1  data valid.
m_axi_rready  out  1  data ready.
tx  out  1  UART serial output; idle high.

Behaviour:
- Reset values: tx=1, busy=0, done=0, err=0, arvalid=0, rready=0, araddr=0. Reset mid-frame forces tx=1 in the next cycle and drops all valids; the interrupted frame is lost.
- CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide; 868 at defaults). Frame = start bit 0, DATA_WIDTH data bits LSB-first, one stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles, so a frame lasts 10*CLKS_PER_BIT = 8680 cycles. Back-to-back bytes within a word have no idle gap.
- FSM states: IDLE, AR, R, SEND, NEXT, FIN.
  - IDLE: on start with num_words≠0, latch the address (aligned) and count, clear err, and go to AR. On start with num_words=0, pulse done in the next cycle; no AXI traffic and busy stays 0.
  - AR: arvalid=1 with a stable araddr until the arvalid&arready handshake, then go to R.
  - R: rready=1. On rvalid, capture rdata into the shift buffer. If rresp≠2'b00, set err and go to FIN without transmitting. Otherwise go to SEND.
  - SEND: transmit bytes 0..15 of the buffer, byte k = rdata[8k+7:8k]. After the stop bit of byte 15, go to NEXT.
  - NEXT: decrement the count and add 16 to the address. Go to AR if the count is not yet 0, else go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- The address wraps modulo 2^AXI_ADDR_WIDTH with no error.
- start while busy is ignored.
- No overlap between outstanding reads and transmission: at most one outstanding read.
- Latency: start to tx falling edge (first start bit) = handshake cycles + 2 cycles minimum (AR 1 cycle, R 1 cycle with zero-wait slave).

Decomposition:
- Shared package axi_uart_pkg holds:
  - state enum;
  - AXI_RESP_OKAY/SLVERR/DECERR constants;
  - BYTES_PER_WORD = AXI_DATA_WIDTH/DATA_WIDTH;
  - a clog2 helper.
- One sub-module, uart_tx, is natural. It has the interface clk, rst, tx_start, tx_data, tx_busy, tx_done, tx, and holds the baud counter, bit counter and shift register. The top module instantiates it once.

Test Plan:
- Memory word at 0x0 = 0xAFAEAD…A1A0; start_addr=0, num_words=1 -> tx carries A0,A1,…,AF in order. Each frame is 8680 cycles and each bit 868 cycles ±0. done pulses once; busy is 0 afterwards; err=0.
- num_words=6, memory filled A0..FF at 0x0..0x50 -> 96 bytes A0..FF sequentially. ARADDR sequence is 0x00,0x10,…,0x50 with exactly 6 AR handshakes.
- Slave holds arready low 20 cycles and delays rvalid 15 cycles -> araddr and arvalid stay stable throughout; no tx activity before the R handshake; output bytes are correct.
- Second word returns rresp=2'b10 -> the 16 bytes of word 0 are sent, no bytes from word 1, err=1, done pulses. A new start clears err.
- num_words=0 -> done pulses one cycle after start; no arvalid; tx stays 1. A start pulse mid-job is ignored (byte count unchanged).
- rst asserted during the data bits of byte 5 -> tx=1, arvalid=0, busy=0 next cycle. A subsequent start works normally.
